// File: rtl/serial_adder_reconstruct_if.sv
// Bundle of serial-adder handshake and data signals.
//   master: drives start, d_bit, b_bit (and c_in when CARRY_IN_EN is defined)
//   slave : drives busy, a_bit, a_valid, a_word, c_out, done
// Optional macro: CARRY_IN_EN adds the c_in carry-in signal.
interface serial_adder_reconstruct_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             d_bit;
  logic             b_bit;
`ifdef CARRY_IN_EN
  logic             c_in;
`endif
  logic             busy;
  logic             a_bit;
  logic             a_valid;
  logic [WIDTH-1:0] a_word;
  logic             c_out;
  logic             done;

`ifdef CARRY_IN_EN
  modport master (
    output start, d_bit, b_bit, c_in,
    input  busy, a_bit, a_valid, a_word, c_out, done
  );
  modport slave (
    input  start, d_bit, b_bit, c_in,
    output busy, a_bit, a_valid, a_word, c_out, done
  );
`else
  modport master (
    output start, d_bit, b_bit,
    input  busy, a_bit, a_valid, a_word, c_out, done
  );
  modport slave (
    input  start, d_bit, b_bit,
    output busy, a_bit, a_valid, a_word, c_out, done
  );
`endif
endinterface

// File: rtl/serial_adder_reconstruct.sv
// Bit-serial LSB-first adder rebuilding a = d + b (mod 2^WIDTH) from a serial
// difference and subtrahend, using one full-adder cell and a carry flop.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - serial_adder_reconstruct_if.slave: start/d_bit/b_bit in,
//          busy/a_bit/a_valid/a_word/c_out/done out
// Optional macro: CARRY_IN_EN - initial carry taken from bus.c_in at start,
//   otherwise the initial carry is 0.
module serial_adder_reconstruct #(
  parameter int unsigned WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst,
  serial_adder_reconstruct_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_bit_q, a_bit_d;
  logic             a_valid_q, a_valid_d;
  logic [WIDTH-1:0] a_word_q, a_word_d;
  logic             c_out_q, c_out_d;

  logic carry_init;
  logic sum;
  logic carry_nxt;

`ifdef CARRY_IN_EN
  assign carry_init = bus.c_in;
`else
  assign carry_init = 1'b0;
`endif

  // Single full-adder cell.
  assign sum       = bus.d_bit ^ bus.b_bit ^ carry_q;
  assign carry_nxt = (bus.d_bit & bus.b_bit) | (bus.d_bit & carry_q) | (bus.b_bit & carry_q);

  always_comb begin
    state_d   = state_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    a_bit_d   = a_bit_q;
    a_valid_d = a_valid_q;
    a_word_d  = a_word_q;
    c_out_d   = c_out_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          carry_d  = carry_init;
          cnt_d    = '0;
          a_word_d = '0;
          c_out_d  = 1'b0;
          state_d  = StShift;
        end
      end
      StShift: begin
        a_bit_d   = sum;
        a_valid_d = 1'b1;
        a_word_d  = {sum, a_word_q[WIDTH-1:1]};
        carry_d   = carry_nxt;
        if (cnt_q == LastCnt) begin
          // Capture the final carry as the last bit is consumed so that
          // c_out is already valid while done is high.
          c_out_d = carry_nxt;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        a_valid_d = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      a_bit_q   <= 1'b0;
      a_valid_q <= 1'b0;
      a_word_q  <= '0;
      c_out_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      a_bit_q   <= a_bit_d;
      a_valid_q <= a_valid_d;
      a_word_q  <= a_word_d;
      c_out_q   <= c_out_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.a_bit   = a_bit_q;
  assign bus.a_valid = a_valid_q;
  assign bus.a_word  = a_word_q;
  assign bus.c_out   = c_out_q;

endmodule

// File: tb/tb_serial_adder_reconstruct.sv
// Self-checking bench for serial_adder_reconstruct (WIDTH=8): directed cases
// plus randomized words, checked every cycle against a timing/arithmetic model.
module tb_serial_adder_reconstruct;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_reconstruct_if #(.WIDTH(W)) bus ();

  serial_adder_reconstruct #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: a word accepted in cycle t0 is busy in t0+1..t0+W+1 and done at t0+W+1.
  bit           in_word = 0;
  int           t0 = 0;
  logic [W-1:0] cur_d, cur_b, cur_a;
  logic         cur_c;
  logic [W-1:0] idle_word = '0;
  logic         idle_c = 1'b0;
  logic [W-1:0] nxt_d, nxt_b;
  logic         nxt_cin;
  bit           chk_en = 0;
  int           done_cnt = 0;
  int           last_done_cyc = -1;
  logic [W-1:0] abit_log = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, then update the model with what the DUT sampled.
  task automatic step(input logic st, input logic rs);
    int           k;
    logic         cin_eff;
    logic [W:0]   full;
    k = cyc;
    if (in_word && k >= t0 + 1 && k <= t0 + int'(W)) begin
      bus.d_bit = cur_d[k-t0-1];
      bus.b_bit = cur_b[k-t0-1];
    end else begin
      bus.d_bit = 1'($urandom);
      bus.b_bit = 1'($urandom);
    end
    bus.start = st;
    rst       = rs;
`ifdef CARRY_IN_EN
    bus.c_in = nxt_cin;
    cin_eff  = nxt_cin;
`else
    cin_eff  = 1'b0;
`endif
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      in_word   = 0;
      idle_word = '0;
      idle_c    = 1'b0;
    end else if (st && !(in_word && k >= t0 + 1 && k <= t0 + int'(W) + 1)) begin
      if (in_word) begin
        idle_word = cur_a;
        idle_c    = cur_c;
      end
      in_word = 1;
      t0      = k;
      cur_d   = nxt_d;
      cur_b   = nxt_b;
      full    = {1'b0, nxt_d} + {1'b0, nxt_b} + {{W{1'b0}}, cin_eff};
      cur_a   = full[W-1:0];
      cur_c   = full[W];
    end
    #1;
  endtask

  // Per-cycle comparison against the model.
  int           n;
  logic [63:0]  sh;
  logic [W-1:0] exp_word;
  always @(negedge clk) begin
    if (chk_en) begin
      if (in_word && cyc >= t0 + 1 && cyc <= t0 + int'(W) + 1) begin
        n  = cyc - t0 - 1;
        sh = 64'(cur_a) << (W - n);
        exp_word = sh[W-1:0];
        check("busy", 64'(bus.busy), 64'd1);
        check("done", 64'(bus.done), 64'(cyc == t0 + int'(W) + 1));
        check("a_valid", 64'(bus.a_valid), 64'(n >= 1));
        if (n >= 1) check("a_bit", 64'(bus.a_bit), 64'(cur_a[n-1]));
        check("a_word", 64'(bus.a_word), 64'(exp_word));
        check("c_out", 64'(bus.c_out), 64'((n == int'(W)) ? cur_c : 1'b0));
      end else begin
        check("busy", 64'(bus.busy), 64'd0);
        check("done", 64'(bus.done), 64'd0);
        check("a_valid", 64'(bus.a_valid), 64'd0);
        check("a_word", 64'(bus.a_word), 64'(in_word ? cur_a : idle_word));
        check("c_out", 64'(bus.c_out), 64'(in_word ? cur_c : idle_c));
      end
      if (bus.a_valid === 1'b1) abit_log = {bus.a_bit, abit_log[W-1:1]};
      if (bus.done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic run_word(input logic [W-1:0] d, input logic [W-1:0] b, input logic cin);
    nxt_d   = d;
    nxt_b   = b;
    nxt_cin = cin;
    step(1'b1, 1'b0);
    repeat (W + 1) step(1'b0, 1'b0);
  endtask

  int s;
  int dc;
  int rpos;
  int gap;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.d_bit = 1'b0;
    bus.b_bit = 1'b0;
`ifdef CARRY_IN_EN
    bus.c_in  = 1'b0;
`endif
    nxt_d = '0; nxt_b = '0; nxt_cin = 1'b0;

    // 1. reset then idle
    step(1'b0, 1'b1);
    chk_en = 1;
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    check("rst_a_bit", 64'(bus.a_bit), 64'd0);
    check("rst_no_done", 64'(done_cnt), 64'd0);

    // 2. 0x05 + 0x03
    s = cyc;
    run_word(8'h05, 8'h03, 1'b0);
    check("t2_done_cycle", 64'(last_done_cyc - s), 64'(W + 1));
    check("t2_model", 64'(cur_a), 64'h08);
    check("t2_a_word", 64'(bus.a_word), 64'h08);
    check("t2_c_out", 64'(bus.c_out), 64'd0);
    check("t2_a_bits", 64'(abit_log), 64'h08);

    // 3. overflow, then carry cleared on the next word
    run_word(8'hFF, 8'h01, 1'b0);
    check("t3_a_word", 64'(bus.a_word), 64'h00);
    check("t3_c_out", 64'(bus.c_out), 64'd1);
    run_word(8'h12, 8'h34, 1'b0);
    check("t3b_a_word", 64'(bus.a_word), 64'h46);
    check("t3b_c_out", 64'(bus.c_out), 64'd0);

    // 4. starts during SHIFT and DONE are ignored
    dc = done_cnt;
    nxt_d = 8'h21; nxt_b = 8'h43; nxt_cin = 1'b0;
    step(1'b1, 1'b0);
    for (int off = 1; off <= int'(W) + 2; off++) step(off == 3 || off == 9, 1'b0);
    check("t4_one_done", 64'(done_cnt - dc), 64'd1);
    check("t4_a_word", 64'(bus.a_word), 64'h64);

    // 5. reset mid-word
    dc = done_cnt;
    nxt_d = 8'h5A; nxt_b = 8'h0F; nxt_cin = 1'b0;
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("t5_busy", 64'(bus.busy), 64'd0);
    check("t5_a_word", 64'(bus.a_word), 64'h00);
    repeat (W) step(1'b0, 1'b0);
    check("t5_no_done", 64'(done_cnt - dc), 64'd0);
    run_word(8'h5A, 8'h0F, 1'b0);
    check("t5_fresh", 64'(bus.a_word), 64'h69);

    // 6. carry-in
    run_word(8'h0F, 8'h00, 1'b1);
`ifdef CARRY_IN_EN
    check("t6_a_word", 64'(bus.a_word), 64'h10);
`else
    check("t6_a_word", 64'(bus.a_word), 64'h0F);
`endif
    check("t6_c_out", 64'(bus.c_out), 64'd0);

    // Randomized words with stray starts and occasional resets
    for (int w = 0; w < 60; w++) begin
      nxt_d   = W'($urandom);
      nxt_b   = W'($urandom);
      nxt_cin = 1'($urandom);
      rpos = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, W + 1)) : 0;
      gap  = int'($urandom_range(0, 3));
      step(1'b1, 1'b0);
      for (int off = 1; off <= int'(W) + 1 + gap; off++) begin
        step(off <= int'(W) + 1 && $urandom_range(0, 5) == 0, off == rpos);
      end
    end
    repeat (W + 3) step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
